mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified 16-bit memory port between the CPU instruction-fetch unit and the load/store unit.
- Issues one memory command at a time and tracks the fixed read latency.
- Returns read data to the requester that issued the read.
- Resolves conflicts round-robin so neither fetch nor load/store starves during tight load loops.

Parameters:
ADDR_W, 16, address width of both requesters and the memory port
DATA_W, 16, data width
MEM_LAT, 1, cycles from mem_en (read) to valid mem_rdata; legal range 1..4

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous active-high reset
if_req  input  1  fetch read request; held until if_gnt
if_addr  input  ADDR_W  fetch address
if_gnt  output  1  fetch command accepted this cycle
if_rdata  output  DATA_W  fetch read data
if_rvalid  output  1  if_rdata valid, one-cycle pulse
ls_req  input  1  load/store request; held until ls_gnt
ls_we  input  1  1 = store, 0 = load
ls_addr  input  ADDR_W  load/store address
ls_wdata  input  DATA_W  store data
ls_gnt  output  1  load/store command accepted this cycle
ls_rdata  output  DATA_W  load read data
ls_rvalid  output  1  ls_rdata valid, one-cycle pulse
mem_en  output  1  memory command strobe
mem_we  output  1  memory write enable, valid with mem_en
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after a read mem_en

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - gnt, rvalid, mem_en and mem_we outputs are 0.
  - rdata outputs, mem_addr and mem_wdata are 0.
  - FSM is in IDLE.
  - last_gnt = LS, so fetch wins the first conflict.
- FSM states:
  - IDLE: may grant.
  - RD_WAIT: read outstanding; latency counter lat_cnt counts 1..MEM_LAT.
- Grant, IDLE only:
  - Grant is combinational from req and state. In the grant cycle, gnt = 1 and mem_en = 1; mem_we, mem_addr and mem_wdata come from the winner.
  - Fetch always has mem_we = 0 and mem_wdata = 0.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester that is not last_gnt wins.
  - last_gnt updates on every grant.
- Read granted in cycle T:
  - FSM goes to RD_WAIT at T+1 and records the owner.
  - mem_rdata is sampled at the end of cycle T+MEM_LAT.
  - The owner's rdata register loads it; the owner's rvalid = 1 for exactly cycle T+MEM_LAT+1.
  - FSM returns to IDLE so the next grant can occur in cycle T+MEM_LAT+1, the same cycle as rvalid.
- Write granted in cycle T: FSM stays IDLE; next grant possible at T+1. No rvalid for stores.
- Port usage limits:
  - No grant while in RD_WAIT; mem_en = 0 there.
  - Maximum throughput is one store per cycle, or one read per MEM_LAT+1 cycles.
- Data hold: rdata registers hold their last value until the next read for that requester. rvalid is never high for both requesters in one cycle.
- Requester contract:
  - addr, we and wdata stay stable while req is high and gnt is low.
  - If req drops before gnt, nothing is issued and last_gnt is unchanged.
  - req held high after gnt is a new request.
- Reset mid-read: the outstanding read is abandoned, no rvalid is produced, and the FSM returns to IDLE.
- lat_cnt is wide enough for 4. For MEM_LAT = 1, RD_WAIT lasts exactly one cycle.

Test Plan:
- Reset and single read: rst 2 cycles; if_req = 1, if_addr = 0x0010, mem returns 0xA5A5 with MEM_LAT = 1 -> if_gnt and mem_en in cycle T with mem_addr = 0x0010; if_rvalid = 1 with if_rdata = 0xA5A5 at T+2 only; ls_rvalid stays 0.
- First conflict: if_req and ls_req both high right after reset -> fetch granted first; ls granted at T+2, the same cycle as if_rvalid; ls waits meanwhile.
- Round robin: both requesters continuously requesting reads for 8 grants -> grants alternate IF, LS, IF, LS...; each rvalid goes to the correct owner with the matching data.
- Store throughput: ls_we = 1, ls_req held 3 cycles with addrs 0x20, 0x21, 0x22 and wdata 0x1111, 0x2222, 0x3333 -> three consecutive mem_en/mem_we cycles with matching addr and data; no ls_rvalid.
- MEM_LAT = 3: load at T from 0x0040 -> mem_en only at T; no grants T+1..T+3 even with if_req high; ls_rvalid at T+4; if_gnt at T+4.
- Reset mid-read: MEM_LAT = 3, load granted, rst asserted at T+2 -> no rvalid ever for that load; outputs take reset values at T+3; a new request is granted after rst deasserts.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared 16-bit memory port.
// Fetch (IF) and load/store (LS) compete round-robin for one command slot.
// Reads block further grants until their data has returned. Writes are
// single-cycle, so stores can stream back to back.
//
// state   | meaning
// IDLE    | port free, a grant may be issued this cycle
// RD_WAIT | read outstanding, lat_cnt runs 1..MEM_LAT, data captured at MEM_LAT
module mem_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_rvalid,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ls_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic { IDLE, RD_WAIT } state_t;
   typedef enum logic { OWN_IF, OWN_LS } own_t;

   state_t            state_q,     state_d;
   own_t              last_gnt_q,  last_gnt_d;
   own_t              owner_q,     owner_d;
   logic [2:0]        lat_cnt_q,   lat_cnt_d;
   logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
   logic [DATA_W-1:0] ls_rdata_q,  ls_rdata_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic              ls_rvalid_q, ls_rvalid_d;

   logic win_if;
   logic win_ls;

   // Round-robin pick: on a conflict the requester not granted last time wins.
   always_comb begin
      win_if = if_req && (!ls_req || (last_gnt_q == OWN_LS));
      win_ls = ls_req && !win_if;
   end

   // Next-state, grant and memory command generation.
   always_comb begin
      state_d     = state_q;
      last_gnt_d  = last_gnt_q;
      owner_d     = owner_q;
      lat_cnt_d   = lat_cnt_q;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      if_rvalid_d = 1'b0;
      ls_rvalid_d = 1'b0;
      if_gnt      = 1'b0;
      ls_gnt      = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      case (state_q)
         IDLE: begin
            // Grants are suppressed during reset so the reset cycle is quiet.
            if (!rst && win_if) begin
               if_gnt     = 1'b1;
               mem_en     = 1'b1;
               mem_addr   = if_addr;
               last_gnt_d = OWN_IF;
               owner_d    = OWN_IF;
               lat_cnt_d  = 3'd1;
               state_d    = RD_WAIT;
            end else if (!rst && win_ls) begin
               ls_gnt     = 1'b1;
               mem_en     = 1'b1;
               mem_we     = ls_we;
               mem_addr   = ls_addr;
               mem_wdata  = ls_wdata;
               last_gnt_d = OWN_LS;
               if (!ls_we) begin
                  owner_d   = OWN_LS;
                  lat_cnt_d = 3'd1;
                  state_d   = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (lat_cnt_q == 3'(MEM_LAT)) begin
               state_d = IDLE;
               if (owner_q == OWN_IF) begin
                  if_rdata_d  = mem_rdata;
                  if_rvalid_d = 1'b1;
               end else begin
                  ls_rdata_d  = mem_rdata;
                  ls_rvalid_d = 1'b1;
               end
            end else begin
               lat_cnt_d = lat_cnt_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and data registers; reset abandons any outstanding read.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_gnt_q  <= OWN_LS;
         owner_q     <= OWN_IF;
         lat_cnt_q   <= 3'd0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         owner_q     <= owner_d;
         lat_cnt_q   <= lat_cnt_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
      end
   end

   assign if_rdata  = if_rdata_q;
   assign ls_rdata  = ls_rdata_q;
   assign if_rvalid = if_rvalid_q;
   assign ls_rvalid = ls_rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) driven by
// directed and random requesters and compared against a cycle-level model
// expressed as "port free from cycle N" plus a pending-read record.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req    [2];
   logic [15:0] if_addr   [2];
   logic        if_gnt    [2];
   logic [15:0] if_rdata  [2];
   logic        if_rvalid [2];
   logic        ls_req    [2];
   logic        ls_we     [2];
   logic [15:0] ls_addr   [2];
   logic [15:0] ls_wdata  [2];
   logic        ls_gnt    [2];
   logic [15:0] ls_rdata  [2];
   logic        ls_rvalid [2];
   logic        mem_en    [2];
   logic        mem_we    [2];
   logic [15:0] mem_addr  [2];
   logic [15:0] mem_wdata [2];
   logic [15:0] mem_rdata [2];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // model state per instance
   int          lat     [2] = '{1, 3};
   int          free_at [2];
   int          pend_cyc[2];
   int          rv_cyc  [2];
   bit          last_ls [2];
   bit          pend    [2];
   bit          pend_ls [2];
   bit          rv_ls   [2];
   bit          g_if    [2];
   bit          g_ls    [2];
   bit          shot_if [2];
   bit          shot_ls [2];
   int          st_idx  [2];
   logic [15:0] i_rd    [2];
   logic [15:0] l_rd    [2];
   logic [15:0] wtab    [3] = '{16'h1111, 16'h2222, 16'h3333};

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst),
      .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
      .if_rdata(if_rdata[0]), .if_rvalid(if_rvalid[0]),
      .ls_req(ls_req[0]), .ls_we(ls_we[0]), .ls_addr(ls_addr[0]),
      .ls_wdata(ls_wdata[0]), .ls_gnt(ls_gnt[0]),
      .ls_rdata(ls_rdata[0]), .ls_rvalid(ls_rvalid[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
      .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
   );

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u_lat3 (
      .clk(clk), .rst(rst),
      .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
      .if_rdata(if_rdata[1]), .if_rvalid(if_rvalid[1]),
      .ls_req(ls_req[1]), .ls_we(ls_we[1]), .ls_addr(ls_addr[1]),
      .ls_wdata(ls_wdata[1]), .ls_gnt(ls_gnt[1]),
      .ls_rdata(ls_rdata[1]), .ls_rvalid(ls_rvalid[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
      .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset(input int k, input int c);
      free_at[k]  = c + 1;
      last_ls[k]  = 1'b1;
      pend[k]     = 1'b0;
      rv_cyc[k]   = -1;
      i_rd[k]     = 16'h0;
      l_rd[k]     = 16'h0;
   endtask

   // Drive one requester pair for instance k according to the stimulus mode.
   task automatic drive(input int k, input int mode);
      bit hold_if, hold_ls;
      hold_if = if_req[k] && !g_if[k];
      hold_ls = ls_req[k] && !g_ls[k];
      mem_rdata[k] = (mode == 1) ? 16'hA5A5 : 16'($urandom);
      case (mode)
         1: begin if_req[k] = !shot_if[k]; if_addr[k] = 16'h0010; end
         2, 5: if (!hold_if) begin if_req[k] = 1'b1; if_addr[k] = 16'($urandom); end
         4: if (!hold_if || $urandom_range(0, 7) == 0) begin
               if_req[k]  = $urandom_range(0, 2) != 0;
               if_addr[k] = 16'($urandom);
            end
         default: if_req[k] = 1'b0;
      endcase
      case (mode)
         2: if (!hold_ls) begin
               ls_req[k] = 1'b1; ls_we[k] = 1'b0;
               ls_addr[k] = 16'($urandom); ls_wdata[k] = 16'($urandom);
            end
         3: begin
               ls_req[k]   = st_idx[k] < 3;
               ls_we[k]    = 1'b1;
               ls_addr[k]  = 16'h0020 + 16'(st_idx[k]);
               ls_wdata[k] = (st_idx[k] < 3) ? wtab[st_idx[k]] : 16'h0;
            end
         4: if (!hold_ls || $urandom_range(0, 7) == 0) begin
               ls_req[k]   = $urandom_range(0, 2) != 0;
               ls_we[k]    = $urandom_range(0, 1) != 0;
               ls_addr[k]  = 16'($urandom);
               ls_wdata[k] = 16'($urandom);
            end
         5, 6: begin ls_req[k] = !shot_ls[k]; ls_we[k] = 1'b0; ls_addr[k] = 16'h0040; end
         default: ls_req[k] = 1'b0;
      endcase
   endtask

   // Compare instance k against the model for the current cycle, then advance the model.
   task automatic check_and_step(input int k, input int mode);
      bit          can, e_if, e_ls, e_we;
      logic [15:0] e_addr, e_wdata;
      string       p;
      p      = $sformatf("lat%0d", lat[k]);
      can    = !rst && (cyc >= free_at[k]);
      e_if   = can && if_req[k] && (!ls_req[k] || last_ls[k]);
      e_ls   = can && ls_req[k] && !e_if;
      e_we   = e_ls && ls_we[k];
      e_addr = e_if ? if_addr[k] : (e_ls ? ls_addr[k] : 16'h0);
      e_wdata = e_ls ? ls_wdata[k] : 16'h0;
      chk({p, " if_gnt"},    {31'd0, if_gnt[k]},    {31'd0, e_if});
      chk({p, " ls_gnt"},    {31'd0, ls_gnt[k]},    {31'd0, e_ls});
      chk({p, " mem_en"},    {31'd0, mem_en[k]},    {31'd0, e_if || e_ls});
      chk({p, " mem_we"},    {31'd0, mem_we[k]},    {31'd0, e_we});
      chk({p, " mem_addr"},  {16'd0, mem_addr[k]},  {16'd0, e_addr});
      chk({p, " mem_wdata"}, {16'd0, mem_wdata[k]}, {16'd0, e_wdata});
      chk({p, " if_rvalid"}, {31'd0, if_rvalid[k]}, {31'd0, rv_cyc[k] == cyc && !rv_ls[k]});
      chk({p, " ls_rvalid"}, {31'd0, ls_rvalid[k]}, {31'd0, rv_cyc[k] == cyc && rv_ls[k]});
      chk({p, " if_rdata"},  {16'd0, if_rdata[k]},  {16'd0, i_rd[k]});
      chk({p, " ls_rdata"},  {16'd0, ls_rdata[k]},  {16'd0, l_rd[k]});
      g_if[k] = e_if;
      g_ls[k] = e_ls;
      if (e_if) shot_if[k] = 1'b1;
      if (e_ls) shot_ls[k] = 1'b1;
      if (e_ls && mode == 3) st_idx[k]++;
      if (rst) begin
         model_reset(k, cyc);
      end else begin
         if (pend[k] && cyc == pend_cyc[k]) begin
            if (pend_ls[k]) l_rd[k] = mem_rdata[k];
            else            i_rd[k] = mem_rdata[k];
            rv_cyc[k] = cyc + 1;
            rv_ls[k]  = pend_ls[k];
            pend[k]   = 1'b0;
         end
         if (e_if || e_ls) begin
            last_ls[k] = e_ls;
            if (!e_we) begin
               pend[k]     = 1'b1;
               pend_ls[k]  = e_ls;
               pend_cyc[k] = cyc + lat[k];
               free_at[k]  = cyc + lat[k] + 1;
            end
         end
      end
   endtask

   // rst_mode: 0 low, 1 high, 2 random pulses.
   task automatic run(input int n, input int mode, input int rst_mode);
      for (int k = 0; k < 2; k++) begin
         shot_if[k] = 1'b0;
         shot_ls[k] = 1'b0;
         st_idx[k]  = 0;
      end
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         rst = (rst_mode == 2) ? ($urandom_range(0, 49) == 0) : (rst_mode == 1);
         for (int k = 0; k < 2; k++) drive(k, mode);
         @(negedge clk);
         for (int k = 0; k < 2; k++) check_and_step(k, mode);
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         if_req[k] = 1'b0; if_addr[k] = 16'h0;
         ls_req[k] = 1'b0; ls_we[k] = 1'b0; ls_addr[k] = 16'h0; ls_wdata[k] = 16'h0;
         mem_rdata[k] = 16'h0;
         g_if[k] = 1'b0; g_ls[k] = 1'b0;
         model_reset(k, -1);
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      run(2, 0, 1);                       // reset values
      run(6, 1, 0);                       // single fetch read returning A5A5
      chk("lat1 a5a5", {16'd0, if_rdata[0]}, 32'h0000A5A5);
      chk("lat3 a5a5", {16'd0, if_rdata[1]}, 32'h0000A5A5);
      run(24, 2, 0);                      // continuous conflicting reads
      run(8, 0, 0);
      run(6, 3, 0);                       // three back-to-back stores
      run(16, 5, 0);                      // load 0x40 with fetch pressure
      run(8, 0, 0);
      run(1, 6, 0);                       // load granted at T
      run(1, 0, 0);
      run(1, 0, 1);                       // reset at T+2
      run(8, 0, 0);
      run(4, 1, 0);                       // new request after reset
      run(3000, 4, 2);                    // random traffic with reset pulses
      run(2, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
